sha256_round_core: RTL

SHA256_ROUND_CORE -- requirements
Module: sha256_round_core

---
 rtl/sha256_round_core.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sha256_round_core.sv
// SHA-256 compression core: 64 rounds of one 512-bit block.
// Latency: done pulses in the 65th cycle after the accepting start edge.
// Backpressure: none; start is only honoured in IDLE and is dropped otherwise.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, Block      request to compress; 2-bit tag captured with start
//   block_in          512-bit message block, W0 in [511:480] .. W15 in [31:0]
//   h_in              initial working values, a in [255:224] .. h in [31:0]
//   busy, done        busy for every round cycle; done is a one-cycle pulse
//   a_out..h_out      working variables after round 63 (no feed-forward)
//   Block_out         tag captured at start, valid with done
module sha256_round_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   Block,
    input  logic [511:0] block_in,
    input  logic [255:0] h_in,
    output logic         busy,
    output logic         done,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic [31:0]  e_out,
    output logic [31:0]  f_out,
    output logic [31:0]  g_out,
    output logic [31:0]  h_out,
    output logic [1:0]   Block_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Power-up values give a defined IDLE state with zeroed outputs even
    // before the first reset.
    state_t      state = IDLE;
    state_t      state_nxt;
    logic [5:0]  t     = '0;
    logic [1:0]  blk_q = '0;
    logic [31:0] a = '0, b = '0, c = '0, d = '0;
    logic [31:0] e = '0, f = '0, g = '0, h = '0;
    // w[0] always holds W[t]; w[15] receives W[t+16] on each round.
    logic [31:0] w [16] = '{default: '0};

    logic [31:0] t1, t2, w_new;

    always_comb begin
        t1    = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + K[t] + w[0];
        t2    = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ROUND;
            ROUND:   if (t == 6'd63) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == ROUND);
        done = (state == DONE);
    end

    // Datapath: working variables, message window, round counter, tag
    always_ff @(posedge clk) begin
        if (rst) begin
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            t     <= '0;
            blk_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        {a, b, c, d, e, f, g, h} <= h_in;
                        for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
                        t     <= '0;
                        blk_q <= Block;
                    end
                end
                ROUND: begin
                    a <= t1 + t2;
                    b <= a;
                    c <= b;
                    d <= c;
                    e <= d + t1;
                    f <= e;
                    g <= f;
                    h <= g;
                    // Schedule words past W63 are computed but never consumed.
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    // Saturate so the counter parks at 63 instead of wrapping.
                    if (t != 6'd63) t <= t + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign a_out     = a;
    assign b_out     = b;
    assign c_out     = c;
    assign d_out     = d;
    assign e_out     = e;
    assign f_out     = f;
    assign g_out     = g;
    assign h_out     = h;
    assign Block_out = blk_q;

endmodule
